// File: rtl/temp_pkg.sv
// Shared definitions for the temperature state controller: one-hot level codes,
// alarm pattern constants and the BCD digit check.
package temp_pkg;

  localparam logic [3:0] NORMAL    = 4'b0001;
  localparam logic [3:0] BORDER    = 4'b0010;
  localparam logic [3:0] ATTENTION = 4'b0100;
  localparam logic [3:0] EMERGENCY = 4'b1000;

  // Wide source patterns; the controller slices its own ALARM_W bits out of these.
  localparam int unsigned ALARM_MAX_W = 64;
  localparam logic [ALARM_MAX_W-1:0] ALARM_ALT  = {32{2'b10}};
  localparam logic [ALARM_MAX_W-1:0] ALARM_ONES = '1;

  typedef enum logic [1:0] {PatOff, PatAlt, PatFull, PatRate} alarm_pat_e;

  function automatic logic bcd_digit_valid(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/temp_level_cmp.sv
// Combinational BCD range classifier: next temperature level from the current
// level, with rise/fall thresholds providing per-level hysteresis.
module temp_level_cmp
  import temp_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] temp,
  input  logic [3:0]   cur_state,
  input  logic [W-1:0] border_rise,
  input  logic [W-1:0] attn_rise,
  input  logic [W-1:0] emerg_rise,
  input  logic [W-1:0] border_fall,
  input  logic [W-1:0] attn_fall,
  input  logic [W-1:0] emerg_fall,
  output logic [3:0]   next_level
);

  logic [3:0] rise_lvl;

  always_comb begin
    if (temp >= emerg_rise)       rise_lvl = EMERGENCY;
    else if (temp >= attn_rise)   rise_lvl = ATTENTION;
    else if (temp >= border_rise) rise_lvl = BORDER;
    else                          rise_lvl = NORMAL;
  end

  always_comb begin
    next_level = cur_state;
    unique case (cur_state)
      NORMAL: next_level = rise_lvl;
      BORDER: begin
        if (rise_lvl == ATTENTION || rise_lvl == EMERGENCY) next_level = rise_lvl;
        else if (temp < border_fall)                        next_level = NORMAL;
      end
      ATTENTION: begin
        if (rise_lvl == EMERGENCY)  next_level = EMERGENCY;
        else if (temp < attn_fall)  next_level = (temp < border_fall) ? NORMAL : BORDER;
      end
      EMERGENCY: begin
        // Falling out of EMERGENCY may skip straight past ATTENTION.
        if (temp < emerg_fall) next_level = rise_lvl;
      end
      default: next_level = rise_lvl;
    endcase
  end

endmodule

// File: rtl/temp_state_ctrl.sv
// Temperature state controller: classifies BCD samples with hysteresis, latches
// emergencies until acknowledged, drives the LED alarm bar. Optional ALARM_BLINK_EN.
module temp_state_ctrl
  import temp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned ALARM_W    = 10,
  parameter logic [4*NUM_DIGITS-1:0] BORDER_RISE = 12'h400,
  parameter logic [4*NUM_DIGITS-1:0] ATTN_RISE   = 12'h470,
  parameter logic [4*NUM_DIGITS-1:0] EMERG_RISE  = 12'h500,
  parameter logic [4*NUM_DIGITS-1:0] BORDER_FALL = 12'h395,
  parameter logic [4*NUM_DIGITS-1:0] ATTN_FALL   = 12'h465,
  parameter logic [4*NUM_DIGITS-1:0] EMERG_FALL  = 12'h495,
  parameter logic [4*NUM_DIGITS-1:0] RATE_TH     = 12'h050,
  parameter int unsigned RATE_ARM   = 2,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [4*NUM_DIGITS-1:0] temp_bcd,
  input  logic [4*NUM_DIGITS-1:0] diff_bcd,
  input  logic                    sign_change,
  input  logic                    ack,
  output logic [3:0]              state,
  output logic [ALARM_W-1:0]      alarm,
  output logic                    latched,
  output logic                    bcd_err
);

  localparam int unsigned W    = 4 * NUM_DIGITS;
  localparam int unsigned ArmW = (RATE_ARM > 0) ? $clog2(RATE_ARM + 1) : 1;

  logic [3:0]         state_q, state_d;
  logic [ALARM_W-1:0] alarm_q, alarm_d;
  logic               latched_q, latched_d;
  logic               bcd_err_q, bcd_err_d;
  logic [ArmW-1:0]    arm_q, arm_d;
  logic [W-1:0]       last_q, last_d;
  alarm_pat_e         pat_q, pat_d;

  logic               sample_ok, armed, ack_clear, phase_d;
  logic [3:0]         ack_lvl, smp_lvl;
  logic [ALARM_W-1:0] alt_pat, rate_pat;

`ifdef ALARM_BLINK_EN
  localparam int unsigned DivW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [DivW-1:0] div_q;
  logic            phase_q;
  logic            div_wrap;

  assign div_wrap = (div_q == DivW'(BLINK_DIV - 1));
  assign phase_d  = div_wrap ? ~phase_q : phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_wrap ? '0 : div_q + DivW'(1);
      phase_q <= phase_d;
    end
  end
`else
  assign phase_d = 1'b0;
`endif

  always_comb begin
    alt_pat               = ALARM_ALT[ALARM_W-1:0];
    rate_pat              = ALARM_ONES[ALARM_W-1:0];
    rate_pat[0]           = 1'b0;
    rate_pat[ALARM_W-1]   = 1'b0;
  end

  // Ack reclassifies from the last accepted temp; a same-cycle sample then
  // classifies from that reclassified level.
  temp_level_cmp #(.W(W)) u_cmp_ack (
    .temp        (last_q),
    .cur_state   (state_q),
    .border_rise (BORDER_RISE),
    .attn_rise   (ATTN_RISE),
    .emerg_rise  (EMERG_RISE),
    .border_fall (BORDER_FALL),
    .attn_fall   (ATTN_FALL),
    .emerg_fall  (EMERG_FALL),
    .next_level  (ack_lvl)
  );

  temp_level_cmp #(.W(W)) u_cmp_smp (
    .temp        (temp_bcd),
    .cur_state   (ack_clear ? ack_lvl : state_q),
    .border_rise (BORDER_RISE),
    .attn_rise   (ATTN_RISE),
    .emerg_rise  (EMERG_RISE),
    .border_fall (BORDER_FALL),
    .attn_fall   (ATTN_FALL),
    .emerg_fall  (EMERG_FALL),
    .next_level  (smp_lvl)
  );

  always_comb begin
    sample_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!bcd_digit_valid(temp_bcd[4*i +: 4]) || !bcd_digit_valid(diff_bcd[4*i +: 4])) begin
        sample_ok = 1'b0;
      end
    end
  end

  assign armed     = (arm_q == ArmW'(RATE_ARM));
  assign ack_clear = ack && latched_q && (last_q < EMERG_FALL);

  always_comb begin
    state_d   = state_q;
    latched_d = latched_q;
    pat_d     = pat_q;
    arm_d     = arm_q;
    last_d    = last_q;
    bcd_err_d = 1'b0;
    if (sign_change) begin
      state_d   = EMERGENCY;
      latched_d = 1'b1;
      pat_d     = PatFull;
    end else begin
      if (ack_clear) begin
        latched_d = 1'b0;
        state_d   = ack_lvl;
      end
      if (sample_valid) begin
        if (!sample_ok) begin
          bcd_err_d = 1'b1;
        end else begin
          last_d = temp_bcd;
          if (!armed) arm_d = arm_q + ArmW'(1);
          if (armed && diff_bcd >= RATE_TH) begin
            state_d   = EMERGENCY;
            latched_d = 1'b1;
            pat_d     = PatRate;
          end else if (!latched_d) begin
            state_d = smp_lvl;
          end
        end
      end
      if (!latched_d) begin
        unique case (state_d)
          ATTENTION: pat_d = PatAlt;
          EMERGENCY: pat_d = PatFull;
          default:   pat_d = PatOff;
        endcase
      end
    end
  end

  always_comb begin
    alarm_d = '0;
    unique case (pat_d)
      PatAlt:  alarm_d = alt_pat ^ {ALARM_W{phase_d}};
      PatFull: alarm_d = phase_d ? '0 : ALARM_ONES[ALARM_W-1:0];
      PatRate: alarm_d = phase_d ? '0 : rate_pat;
      default: alarm_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NORMAL;
      alarm_q   <= '0;
      latched_q <= 1'b0;
      bcd_err_q <= 1'b0;
      arm_q     <= '0;
      last_q    <= '0;
      pat_q     <= PatOff;
    end else begin
      state_q   <= state_d;
      alarm_q   <= alarm_d;
      latched_q <= latched_d;
      bcd_err_q <= bcd_err_d;
      arm_q     <= arm_d;
      last_q    <= last_d;
      pat_q     <= pat_d;
    end
  end

  assign state   = state_q;
  assign alarm   = alarm_q;
  assign latched = latched_q;
  assign bcd_err = bcd_err_q;

endmodule

// File: tb/tb_temp_state_ctrl.sv
// Self-checking bench for temp_state_ctrl (default build, ALARM_BLINK_EN undefined).
module tb_temp_state_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] temp_bcd = '0;
  logic [11:0] diff_bcd = '0;
  logic        sign_change = 1'b0;
  logic        ack = 1'b0;
  logic [3:0]  state;
  logic [9:0]  alarm;
  logic        latched;
  logic        bcd_err;

  localparam logic [3:0] SN = 4'b0001, SB = 4'b0010, SA = 4'b0100, SE = 4'b1000;
  localparam logic [9:0] A0 = 10'b0000000000, AALT = 10'b1010101010;
  localparam logic [9:0] AONE = 10'b1111111111, ARATE = 10'b0111111110;

  typedef struct {
    logic        sv;
    logic [11:0] t;
    logic [11:0] d;
    logic        sc;
    logic        ak;
    logic [15:0] exp;  // {state, alarm, latched, bcd_err}
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;
  logic [15:0] sb[$];

  temp_state_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .temp_bcd     (temp_bcd),
    .diff_bcd     (diff_bcd),
    .sign_change  (sign_change),
    .ack          (ack),
    .state        (state),
    .alarm        (alarm),
    .latched      (latched),
    .bcd_err      (bcd_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic sv, input logic [11:0] t, input logic [11:0] d,
                              input logic sc, input logic ak, input logic [3:0] st,
                              input logic [9:0] al, input logic la, input logic be);
    vec_t v;
    v.sv = sv; v.t = t; v.d = d; v.sc = sc; v.ak = ak;
    v.exp = {st, al, la, be};
    return v;
  endfunction

  // Drives one cycle of stimulus and leaves time at posedge+1 for sampling.
  task automatic drive(input vec_t v);
    @(negedge clk);
    sample_valid = v.sv; temp_bcd = v.t; diff_bcd = v.d; sign_change = v.sc; ack = v.ak;
    @(posedge clk);
    #1;
    sample_valid = 1'b0; sign_change = 1'b0; ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back({SN, A0, 1'b0, 1'b0});
    e = sb.pop_front();
    n_vec++;
    if ({state, alarm, latched, bcd_err} !== e) begin
      n_fail++;
      $display("FAIL reset: got st=%b al=%b la=%b be=%b, want %b", state, alarm, latched,
               bcd_err, e);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_levels();
    vec_t v[$];
    logic [15:0] e;
    v.push_back(mk(1, 12'h399, 12'h000, 0, 0, SN, A0,   0, 0));
    v.push_back(mk(1, 12'h400, 12'h000, 0, 0, SB, A0,   0, 0));
    v.push_back(mk(1, 12'h470, 12'h000, 0, 0, SA, AALT, 0, 0));
    v.push_back(mk(1, 12'h500, 12'h000, 0, 0, SE, AONE, 0, 0));
    v.push_back(mk(1, 12'h495, 12'h000, 0, 0, SE, AONE, 0, 0));
    v.push_back(mk(1, 12'h494, 12'h000, 0, 0, SA, AALT, 0, 0));
    v.push_back(mk(1, 12'h466, 12'h000, 0, 0, SA, AALT, 0, 0));
    v.push_back(mk(0, 12'h466, 12'h000, 0, 1, SA, AALT, 0, 0));
    v.push_back(mk(1, 12'h464, 12'h000, 0, 0, SB, A0,   0, 0));
    v.push_back(mk(1, 12'h395, 12'h000, 0, 0, SB, A0,   0, 0));
    v.push_back(mk(1, 12'h394, 12'h000, 0, 0, SN, A0,   0, 0));
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i]);
      sb.push_back(v[i].exp);
      e = sb.pop_front();
      n_vec++;
      if ({state, alarm, latched, bcd_err} !== e) begin
        n_fail++;
        $display("FAIL levels[%0d]: got st=%b al=%b la=%b be=%b, want %b", i, state, alarm,
                 latched, bcd_err, e);
      end
    end
  endtask

  task automatic test_rate();
    vec_t v[$];
    logic [15:0] e;
    do_reset();
    v.push_back(mk(1, 12'h300, 12'h090, 0, 0, SN, A0,    0, 0));
    v.push_back(mk(1, 12'h300, 12'h000, 0, 0, SN, A0,    0, 0));
    v.push_back(mk(1, 12'h300, 12'h050, 0, 0, SE, ARATE, 1, 0));
    v.push_back(mk(1, 12'h300, 12'h049, 0, 0, SE, ARATE, 1, 0));
    v.push_back(mk(0, 12'h300, 12'h000, 0, 1, SN, A0,    0, 0));
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i]);
      sb.push_back(v[i].exp);
      e = sb.pop_front();
      n_vec++;
      if ({state, alarm, latched, bcd_err} !== e) begin
        n_fail++;
        $display("FAIL rate[%0d]: got st=%b al=%b la=%b be=%b, want %b", i, state, alarm,
                 latched, bcd_err, e);
      end
    end
  endtask

  task automatic test_sign_change();
    vec_t v[$];
    logic [15:0] e;
    v.push_back(mk(1, 12'h520, 12'h000, 0, 0, SE, AONE, 0, 0));
    v.push_back(mk(0, 12'h520, 12'h000, 1, 0, SE, AONE, 1, 0));
    v.push_back(mk(0, 12'h520, 12'h000, 0, 1, SE, AONE, 1, 0));
    v.push_back(mk(1, 12'h200, 12'h000, 0, 0, SE, AONE, 1, 0));
    v.push_back(mk(0, 12'h200, 12'h000, 0, 1, SN, A0,   0, 0));
    v.push_back(mk(0, 12'h200, 12'h000, 1, 1, SE, AONE, 1, 0));
    v.push_back(mk(1, 12'h470, 12'h000, 0, 1, SA, AALT, 0, 0));
    v.push_back(mk(0, 12'h470, 12'h000, 1, 0, SE, AONE, 1, 0));
    v.push_back(mk(0, 12'h470, 12'h000, 0, 1, SA, AALT, 0, 0));
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i]);
      sb.push_back(v[i].exp);
      e = sb.pop_front();
      n_vec++;
      if ({state, alarm, latched, bcd_err} !== e) begin
        n_fail++;
        $display("FAIL sign[%0d]: got st=%b al=%b la=%b be=%b, want %b", i, state, alarm,
                 latched, bcd_err, e);
      end
    end
  endtask

  task automatic test_bcd_err();
    vec_t v[$];
    logic [15:0] e;
    do_reset();
    v.push_back(mk(1, 12'h4A0, 12'h000, 0, 0, SN, A0,    0, 1));
    v.push_back(mk(0, 12'h4A0, 12'h000, 0, 0, SN, A0,    0, 0));
    v.push_back(mk(1, 12'h300, 12'h0B0, 0, 0, SN, A0,    0, 1));
    v.push_back(mk(1, 12'h300, 12'h090, 0, 0, SN, A0,    0, 0));
    v.push_back(mk(1, 12'h300, 12'h090, 0, 0, SN, A0,    0, 0));
    v.push_back(mk(1, 12'h300, 12'h090, 0, 0, SE, ARATE, 1, 0));
    v.push_back(mk(1, 12'h5F0, 12'h000, 0, 0, SE, ARATE, 1, 1));
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i]);
      sb.push_back(v[i].exp);
      e = sb.pop_front();
      n_vec++;
      if ({state, alarm, latched, bcd_err} !== e) begin
        n_fail++;
        $display("FAIL bcd[%0d]: got st=%b al=%b la=%b be=%b, want %b", i, state, alarm,
                 latched, bcd_err, e);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t v[$];
    logic [15:0] e;
    // Previous test left the block latched in a rate EMERGENCY.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.push_back({SN, A0, 1'b0, 1'b0});
    e = sb.pop_front();
    n_vec++;
    if ({state, alarm, latched, bcd_err} !== e) begin
      n_fail++;
      $display("FAIL async_rst: got st=%b al=%b la=%b be=%b, want %b", state, alarm, latched,
               bcd_err, e);
    end
    @(negedge clk);
    rst = 1'b0;
    v.push_back(mk(1, 12'h300, 12'h090, 0, 0, SN, A0,    0, 0));
    v.push_back(mk(1, 12'h300, 12'h090, 0, 0, SN, A0,    0, 0));
    v.push_back(mk(1, 12'h300, 12'h060, 0, 0, SE, ARATE, 1, 0));
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i]);
      sb.push_back(v[i].exp);
      e = sb.pop_front();
      n_vec++;
      if ({state, alarm, latched, bcd_err} !== e) begin
        n_fail++;
        $display("FAIL post_rst[%0d]: got st=%b al=%b la=%b be=%b, want %b", i, state, alarm,
                 latched, bcd_err, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_levels();
    test_rate();
    test_sign_change();
    test_bcd_err();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/temp_state_ctrl.md
Name: temp_state_ctrl

Overview:
- Clocked, parametrised successor to the temperature-state classifier. It takes packed-BCD temperature and delta samples qualified by a valid strobe.
- Classifies each sample into NORMAL/BORDER/ATTENTION/EMERGENCY with per-level hysteresis.
- Latches emergencies until the operator acknowledges them, and drives the LED alarm bar.
- Sits between the BCD conversion/difference stage and the display/LED drivers.

Parameters:
- NUM_DIGITS, 3, BCD digits per sample (sample width = 4*NUM_DIGITS)
- ALARM_W, 10, alarm LED bar width
- BORDER_RISE, 12'h400, BCD threshold to enter BORDER (40.0)
- ATTN_RISE, 12'h470, BCD threshold to enter ATTENTION (47.0)
- EMERG_RISE, 12'h500, BCD threshold to enter EMERGENCY (50.0)
- BORDER_FALL, 12'h395, leave BORDER downward when temp < this
- ATTN_FALL, 12'h465, leave ATTENTION downward when temp < this
- EMERG_FALL, 12'h495, leave EMERGENCY downward when temp < this
- RATE_TH, 12'h050, delta magnitude that forces EMERGENCY
- RATE_ARM, 2, valid samples required after reset before the rate check is armed
- BLINK_DIV, 25000000, clocks per blink phase (used only with ALARM_BLINK_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sample_valid  in  1  one-cycle strobe; temp_bcd and diff_bcd are valid in that cycle
- temp_bcd  in  4*NUM_DIGITS  temperature, packed BCD, one implied decimal place
- diff_bcd  in  4*NUM_DIGITS  absolute delta from previous sample, packed BCD
- sign_change  in  1  one-cycle pulse: sign mode changed
- ack  in  1  one-cycle pulse: operator acknowledge
- state  out  4  one-hot: 0001 NORMAL, 0010 BORDER, 0100 ATTENTION, 1000 EMERGENCY
- alarm  out  ALARM_W  LED pattern
- latched  out  1  emergency latch active
- bcd_err  out  1  one-cycle pulse: rejected sample

Behaviour:
- Reset (asynchronous): state=NORMAL, alarm=0, latched=0, bcd_err=0, arm counter=0, blink phase=0.
- All outputs are registered. A qualifying sample_valid in cycle N updates the outputs in cycle N+1.
- Priority within one cycle is rst > sign_change > ack > sample_valid.
- BCD check: if any nibble of temp_bcd or diff_bcd exceeds 9, the sample is ignored. bcd_err pulses for one cycle, and state, latched and the arm counter are unchanged.
- Comparison: packed-BCD values are compared as unsigned integers, which is valid for legal BCD.
- Arm counter: increments on each accepted sample and saturates at RATE_ARM. The rate check is active only when the counter equals RATE_ARM, so the first RATE_ARM samples after reset are never rate-checked.
- sign_change: state=EMERGENCY, latched=1, alarm=all ones.
- Rate event: armed and diff_bcd >= RATE_TH. Sets state=EMERGENCY and latched=1; alarm = all ones with both end bits cleared (0111111110 at ALARM_W=10).
- While latched=1: accepted samples do not change state. ack clears latched only when the last accepted temp < EMERG_FALL; then state is reclassified from that temp in the next cycle. An ack in any other case is ignored.
- Hysteresis (latched=0), evaluated on each accepted sample:
  - Upward transitions use the _RISE thresholds, taking the highest level met.
  - From ATTENTION, temp < ATTN_FALL drops to BORDER, or to NORMAL if also < BORDER_FALL.
  - From EMERGENCY, temp < EMERG_FALL drops to the level given by the _RISE thresholds, which may be lower than ATTENTION.
  - From BORDER, temp < BORDER_FALL drops to NORMAL.
  - Otherwise the state is held.
  - A temperature-only EMERGENCY does not set latched.
- Alarm by state:
  - NORMAL and BORDER: all zero.
  - ATTENTION: alternating bits, 1010101010 at ALARM_W=10.
  - EMERGENCY (temperature or sign_change): all ones.
- ack without latched: ignored. sample_valid and ack in the same cycle: ack is evaluated first against the prior temp, then the new sample classifies.

Optional Feature:
- Macro: ALARM_BLINK_EN.
- Defined: the ATTENTION pattern inverts every BLINK_DIV clocks (1010101010 <-> 0101010101), and the EMERGENCY patterns alternate with all zero. The divider runs free from reset.
- Undefined: patterns are static and no divider logic is present.

Decomposition:
- Shared package temp_pkg holds:
  - State one-hot localparams (NORMAL, BORDER, ATTENTION, EMERGENCY)
  - Alarm pattern generator constants
  - The BCD-digit-valid function
- One sub-module, temp_level_cmp: combinational BCD range classifier that takes temp, current state and the six thresholds and returns the next level.

Test Plan:
- Reset, then samples 12'h399, 12'h400, 12'h470, 12'h500 -> states 0001, 0010, 0100, 1000 at N+1 each; alarm 0, 0, 1010101010, 1111111111.
- From ATTENTION, sample 12'h466 -> stays ATTENTION; then 12'h464 -> BORDER; then 12'h394 -> NORMAL.
- After reset, sample 1 with diff 12'h090 -> no rate emergency. Sample 3 with diff 12'h050 -> EMERGENCY, alarm 0111111110, latched=1. ack with temp 12'h300 -> latched=0, state NORMAL.
- sign_change while temp=12'h520; ack -> ignored (temp not < 12'h495). Sample 12'h200 then ack -> NORMAL.
- Sample temp 12'h4A0 -> bcd_err one-cycle pulse; state and arm counter unchanged.
- Assert rst asynchronously mid-EMERGENCY between clock edges -> all outputs reset immediately. The next two samples are not rate-checked.
